em4100_encoder_param: RTL
=========================

Name: em4100_encoder_param

Overview:
Parametrised EM4100 transponder encoder, next generation of the fixed-rate EM4100 block. It builds the 64-bit EM4100 frame from a 40-bit ID: header, row parities, column parities and stop bit. The frame is serialised with Manchester or biphase coding at a configurable half-bit period. Adds a repeat count, continuous mode, graceful stop and busy/done/frame_start status for a controller or the modulator front-end.

Parameters:
HALF_BIT_CLKS, 1, clk cycles per half-bit (>=1); bit period = 2*HALF_BIT_CLKS.
RPT_W, 8, width of the repeat-count port.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
tx  input  1  start request; sampled only while idle.
data  input  40  card ID; data[39:36] is the first nibble sent.
mode  input  1  0 = Manchester, 1 = biphase; latched with data.
rpt  input  RPT_W  frames to send; 0 = continuous.
stop  input  1  request end after the current frame completes.
q  output  1  encoded serial output.
busy  output  1  high from accept until the last half-bit ends.
frame_start  output  1  one-cycle pulse on the first cycle of each frame.
done  output  1  one-cycle pulse on the cycle after the last half-bit.

Behaviour:
- Reset (rst=1 at edge): state IDLE; q=0, busy=0, frame_start=0, done=0. All counters, latches and the biphase level are cleared. Reset mid-frame aborts immediately.
- Frame, 64 bits in order:
  - 9 ones.
  - 10 rows, each 4 data bits MSB-first (row r = data[39-4r -: 4]) followed by an even-parity bit (XOR of the nibble).
  - 4 column parities, col0 first, each the XOR of bit k of all 10 nibbles (col0 = nibble MSB).
  - stop bit 0.
- FSM IDLE -> SEND -> (SEND | IDLE).
  - IDLE, tx=1: latch data, mode and rpt. Assert busy the next cycle. Build the frame in a 64-bit shift register or equivalent.
  - tx is level-sampled: held high, it restarts one cycle after done.
- Latency: first half of bit 0 appears on q in the cycle after tx is accepted. frame_start is high in that same cycle.
- Each half-bit lasts exactly HALF_BIT_CLKS cycles, so a frame is 128*HALF_BIT_CLKS cycles.
- Manchester: bit 1 = high then low; bit 0 = low then high.
- Biphase:
  - level register B (reset 0) inverts at the start of every bit.
  - bit 1: B is held for the whole bit.
  - bit 0: B inverts again at mid-bit.
  - B carries across frames; it is cleared only by reset or on return to IDLE.
- End of frame:
  - rpt!=0: frames count up to rpt, then end.
  - rpt=0: frames repeat back-to-back until stop.
  - Back-to-back frames have no gap cycles; frame_start pulses on each first cycle.
- stop:
  - sticky once seen while busy; the current frame always completes in full.
  - If stop is seen during the last frame of a counted run, there is no extra effect.
  - stop in IDLE is ignored.
- Completion:
  - After the final half-bit: busy=0, done=1 for one cycle, q=0, return to IDLE.
  - tx is accepted no earlier than the cycle done is high (IDLE that cycle).
- data, mode and rpt changes while busy are ignored until the next accept.
- Simultaneous rst and tx: rst wins.

Test Plan:
1. HALF_BIT_CLKS=1, rpt=1, mode=0, data=40'hBEDEADBEEF, pulse tx:
   - decoded bit stream = 9x1, then BE DE AD BE EF nibbles with row parities 1,1,1,1,0,1,1,1,1,0, then columns 0101, then stop 0.
   - q = 1,0 per header bit; busy for 128 cycles; done one cycle later.
2. data=0, mode=0, rpt=1 -> 9 ones then 55 zeros; q = 0,1 per zero bit; frame_start exactly once.
3. mode=1, data=40'hBEDEADBEEF -> q inverts every bit boundary and additionally at mid-bit only for 0 bits; decoding returns the same 64 bits as test 1.
4. HALF_BIT_CLKS=4, rpt=3 -> 3 frame_start pulses 512 cycles apart; busy for 1536 cycles; single done.
5. rpt=0, assert stop for 1 cycle mid-frame 2 -> frame 2 completes in full, no frame 3, done after 256*HALF_BIT_CLKS cycles.
6. Assert rst at cycle 40 of a frame -> next cycle q=0, busy=0, no done. A tx issued after reset restarts from the header.

Source files
------------

// File: rtl/em4100_encoder_param.sv
// EM4100 transponder encoder: builds the 64-bit frame from a 40-bit ID and
// serialises it Manchester- or biphase-coded, with repeat count, continuous mode and stop.
module em4100_encoder_param #(
    parameter int unsigned HALF_BIT_CLKS = 1,
    parameter int unsigned RPT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx,
    input  logic [39:0]      data,
    input  logic             mode,
    input  logic [RPT_W-1:0] rpt,
    input  logic             stop,
    output logic             q,
    output logic             busy,
    output logic             frame_start,
    output logic             done
);

    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned BIT_W      = 6;
    localparam int unsigned HC_W       = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HALF_BIT_CLKS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Frame layout, MSB sent first: header, 10 rows of nibble+parity, column parities, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [39:0] id);
        logic [FRAME_BITS-1:0] f;
        logic [3:0]            nib;
        logic [3:0]            col;
        f   = '0;
        col = '0;
        f[63:55] = 9'h1FF;
        for (int r = 0; r < 10; r++) begin
            nib = id[39-4*r -: 4];
            f[54-5*r -: 5] = {nib, ^nib};
            col = col ^ nib;
        end
        f[4:1] = col;
        f[0]   = 1'b0;
        return f;
    endfunction

    state_t                state, state_n;
    logic [FRAME_BITS-1:0] frame_r, frame_n;
    logic                  mode_r, mode_n;
    logic [RPT_W-1:0]      rpt_r, rpt_n;
    logic [RPT_W-1:0]      fcnt, fcnt_n;
    logic                  stop_seen, stop_seen_n;
    logic [BIT_W-1:0]      bit_idx, bit_idx_n;
    logic                  half, half_n;
    logic [HC_W-1:0]       hcnt, hcnt_n;
    logic                  bq, bq_n;
    logic                  q_n, busy_n, frame_start_n, done_n;

    logic [FRAME_BITS-1:0] acc_frame;
    logic [BIT_W-1:0]      bit_nx;
    logic                  cur_bit, nxt_bit, first_bit;
    logic [RPT_W-1:0]      fcnt_inc;
    logic                  half_end, frame_end, last_frame;

    assign acc_frame  = build_frame(data);
    assign bit_nx     = bit_idx + BIT_W'(1);
    assign cur_bit    = frame_r[~bit_idx];
    assign nxt_bit    = frame_r[~bit_nx];
    assign first_bit  = frame_r[FRAME_BITS-1];
    assign fcnt_inc   = fcnt + RPT_W'(1);
    assign half_end   = (hcnt == HC_LAST);
    assign frame_end  = half_end && half && (bit_idx == BIT_LAST);
    // A stop arriving on the very last cycle of a frame still ends the run there.
    assign last_frame = (rpt_r != '0) ? (fcnt_inc == rpt_r) : (stop_seen | stop);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (tx) state_n = SEND;
            SEND: if (frame_end && last_frame) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath and next output values; q is the biphase level bq when mode_r is set
    always_comb begin
        frame_n       = frame_r;
        mode_n        = mode_r;
        rpt_n         = rpt_r;
        fcnt_n        = fcnt;
        stop_seen_n   = stop_seen;
        bit_idx_n     = bit_idx;
        half_n        = half;
        hcnt_n        = hcnt;
        bq_n          = bq;
        q_n           = q;
        busy_n        = busy;
        frame_start_n = 1'b0;
        done_n        = 1'b0;

        case (state)
            IDLE: begin
                q_n         = 1'b0;
                busy_n      = 1'b0;
                bq_n        = 1'b0;
                stop_seen_n = 1'b0;
                if (tx) begin
                    frame_n       = acc_frame;
                    mode_n        = mode;
                    rpt_n         = rpt;
                    fcnt_n        = '0;
                    bit_idx_n     = '0;
                    half_n        = 1'b0;
                    hcnt_n        = '0;
                    bq_n          = ~bq;
                    q_n           = mode ? ~bq : acc_frame[FRAME_BITS-1];
                    busy_n        = 1'b1;
                    frame_start_n = 1'b1;
                end
            end

            SEND: begin
                busy_n      = 1'b1;
                stop_seen_n = stop_seen | stop;
                if (!half_end) begin
                    hcnt_n = hcnt + HC_W'(1);
                end else begin
                    hcnt_n = '0;
                    if (!half) begin
                        // Mid-bit: Manchester inverts, biphase inverts only for a 0
                        half_n = 1'b1;
                        bq_n   = cur_bit ? bq : ~bq;
                        q_n    = mode_r ? bq_n : ~cur_bit;
                    end else if (!frame_end) begin
                        half_n    = 1'b0;
                        bit_idx_n = bit_nx;
                        bq_n      = ~bq;
                        q_n       = mode_r ? ~bq : nxt_bit;
                    end else if (last_frame) begin
                        half_n    = 1'b0;
                        bit_idx_n = '0;
                        bq_n      = 1'b0;
                        q_n       = 1'b0;
                        busy_n    = 1'b0;
                        done_n    = 1'b1;
                    end else begin
                        // Back-to-back frame with no gap; biphase level carries over
                        fcnt_n        = fcnt_inc;
                        half_n        = 1'b0;
                        bit_idx_n     = '0;
                        bq_n          = ~bq;
                        q_n           = mode_r ? ~bq : first_bit;
                        frame_start_n = 1'b1;
                    end
                end
            end

            default: begin
                q_n    = 1'b0;
                busy_n = 1'b0;
                bq_n   = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_r     <= '0;
            mode_r      <= 1'b0;
            rpt_r       <= '0;
            fcnt        <= '0;
            stop_seen   <= 1'b0;
            bit_idx     <= '0;
            half        <= 1'b0;
            hcnt        <= '0;
            bq          <= 1'b0;
            q           <= 1'b0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            frame_r     <= frame_n;
            mode_r      <= mode_n;
            rpt_r       <= rpt_n;
            fcnt        <= fcnt_n;
            stop_seen   <= stop_seen_n;
            bit_idx     <= bit_idx_n;
            half        <= half_n;
            hcnt        <= hcnt_n;
            bq          <= bq_n;
            q           <= q_n;
            busy        <= busy_n;
            frame_start <= frame_start_n;
            done        <= done_n;
        end
    end

endmodule
